// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - three-source interrupt controller driving the IRQ/IACK/IEND handshake
// Optional acknowledge timeout is built when INTC_TIMEOUT_EN is defined.
module irq_controller #(
    parameter int NUM_SRC     = 3,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_SRC-1:0] SRC_REQ,
    output logic [1:0]         INT_IRQ,
    input  logic               INT_IACK,
    input  logic               INT_IEND,
    output logic [NUM_SRC-1:0] SRC_ACK,
    output logic [NUM_SRC-1:0] SRC_DONE,
    output logic [NUM_SRC-1:0] PENDING,
    output logic [NUM_SRC-1:0] OVERRUN,
    output logic               PROTO_ERR,
    output logic               TIMEOUT
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } stateT;

    stateT              state;
    logic [1:0]         curCode;
    logic [NUM_SRC-1:0] reqPrev;
    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] codeMask;
    logic [NUM_SRC-1:0] clearMask;
    logic [1:0]         winCode;

`ifdef INTC_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    logic [CNT_W-1:0] ackCnt;
`else
    logic unusedAckTimeout;
    assign unusedAckTimeout = (ACK_TIMEOUT > 0);
`endif

    assign edges    = SRC_REQ & ~reqPrev;
    assign codeMask = NUM_SRC'(1) << (curCode - 2'd1);
    // An acknowledge clears the in-service bit, but a coincident new edge re-sets it below.
    assign clearMask = (state == REQ && INT_IACK) ? codeMask : '0;

    always_comb begin
        winCode = 2'd0;
        if (PENDING[0])
            winCode = 2'd1;
        else if (PENDING[1])
            winCode = 2'd2;
        else if (PENDING[2])
            winCode = 2'd3;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            curCode   <= 2'd0;
            reqPrev   <= '0;
            INT_IRQ   <= 2'd0;
            SRC_ACK   <= '0;
            SRC_DONE  <= '0;
            PENDING   <= '0;
            OVERRUN   <= '0;
            PROTO_ERR <= 1'b0;
            TIMEOUT   <= 1'b0;
`ifdef INTC_TIMEOUT_EN
            ackCnt    <= '0;
`endif
        end else begin
            SRC_ACK   <= '0;
            SRC_DONE  <= '0;
            TIMEOUT   <= 1'b0;
            reqPrev   <= SRC_REQ;
            PENDING   <= (PENDING & ~clearMask) | edges;
            OVERRUN   <= OVERRUN | (edges & PENDING & ~clearMask);
            PROTO_ERR <= PROTO_ERR
                         | (INT_IACK & (state != REQ))
                         | (INT_IEND & (state != SERVICE));

            case (state)
                IDLE: begin
                    if (winCode != 2'd0) begin
                        curCode <= winCode;
                        INT_IRQ <= winCode;
                        state   <= REQ;
`ifdef INTC_TIMEOUT_EN
                        ackCnt  <= '0;
`endif
                    end
                end
                REQ: begin
                    if (INT_IACK) begin
                        SRC_ACK <= codeMask;
                        INT_IRQ <= 2'd0;
                        state   <= SERVICE;
                    end
`ifdef INTC_TIMEOUT_EN
                    else if (ackCnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        TIMEOUT <= 1'b1;
                        INT_IRQ <= 2'd0;
                        state   <= IDLE;
                    end else begin
                        ackCnt <= ackCnt + 1'b1;
                    end
`endif
                end
                SERVICE: begin
                    if (INT_IEND) begin
                        SRC_DONE <= codeMask;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt controller on the responder side of the processor interrupt handshake. Processor interface signals: INT_IRQ, INT_IACK, INT_IEND.
- Latches rising-edge requests from up to three peripheral sources and presents the highest-priority pending one as a 2-bit IRQ code.
- Sequences the IACK/IEND handshake and forwards per-source acknowledge and done pulses, so a peripheral (e.g. the keyboard controller) knows when to present data and when service is complete.

Parameters:
- NUM_SRC, 3, number of request sources. Fixed at 3, because code 0 means "no interrupt".
- ACK_TIMEOUT, 1024, cycles allowed in REQ without IACK. Used only when INTC_TIMEOUT_EN is defined.

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- SRC_REQ  input  3  request lines; bit k-1 is source k; rising edge = one request
- INT_IRQ  output  2  code of the interrupt presented to the processor; 0 = none
- INT_IACK  input  1  processor acknowledge, one-cycle pulse
- INT_IEND  input  1  processor end-of-service, one-cycle pulse
- SRC_ACK  output  3  one-hot, one-cycle pulse to the acknowledged source
- SRC_DONE  output  3  one-hot, one-cycle pulse to the source whose service ended
- PENDING  output  3  current pending bits
- OVERRUN  output  3  sticky; a new edge arrived while that source was still pending
- PROTO_ERR  output  1  sticky; IACK outside REQ, or IEND outside SERVICE
- TIMEOUT  output  1  one-cycle pulse on ACK timeout (INTC_TIMEOUT_EN only; else tied 0)

Behaviour:
- All outputs registered. Reset values: INT_IRQ=0, SRC_ACK=0, SRC_DONE=0, PENDING=0, OVERRUN=0, PROTO_ERR=0, TIMEOUT=0, state=IDLE, edge-detect history=0, in-service code=0.
- RESET mid-handshake returns to IDLE at once and drops every pending request; no SRC_DONE is issued.
- Edge detect: a registered copy of SRC_REQ is kept. An edge is cur=1 with prev=0, seen at clock edge E. PENDING[k] is high after E.
- OVERRUN[k] is set when an edge arrives while PENDING[k] is already 1. The duplicate request is merged, not queued.
- Priority: lowest code wins (1 > 2 > 3).
- State machine:
  - IDLE: if any PENDING bit is set, latch the winning code and go to REQ. INT_IRQ=code from the next cycle, so INT_IRQ is nonzero 2 cycles after the request edge.
  - REQ: INT_IRQ holds the latched code; a new higher-priority pending does not pre-empt. On INT_IACK=1:
    - clear PENDING[code];
    - pulse SRC_ACK[code] next cycle;
    - INT_IRQ=0 next cycle;
    - go to SERVICE.
  - SERVICE: INT_IRQ=0; wait for INT_IEND. On INT_IEND=1, pulse SRC_DONE[code] next cycle and go to IDLE.
  - IDLE after SERVICE: the next pending source is presented again 1 cycle later. The processor is back in its wait state by then.
- Same-cycle set and clear: if PENDING[code] is cleared by IACK while a new edge on the same source arrives, the set wins. PENDING stays 1 and OVERRUN is not set.
- IACK and IEND both high in one cycle: only the one valid for the current state is honoured; the other sets PROTO_ERR.
- A stray IACK (not in REQ) or stray IEND (not in SERVICE) sets PROTO_ERR and causes no state change.
- PROTO_ERR and OVERRUN clear only on RESET.

Optional Feature:
- Macro INTC_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 on entry to REQ and increments each REQ cycle.
  - If it reaches ACK_TIMEOUT without INT_IACK: pulse TIMEOUT, drive INT_IRQ=0, return to IDLE. The source stays pending and is re-presented by IDLE.
  - IACK in the same cycle the count is reached takes precedence: normal acknowledge, no TIMEOUT.
- Undefined: REQ waits indefinitely, no counter logic exists, and TIMEOUT is constant 0.

Test Plan:
- Reset, then SRC_REQ=001 edge at cycle 10 → PENDING=001 after cycle 10 and INT_IRQ=1 after cycle 11. IACK at 15 → SRC_ACK=001 for one cycle, INT_IRQ=0, PENDING=000. IEND at 20 → SRC_DONE=001 for one cycle, then IDLE.
- SRC_REQ=110 edges in the same cycle → INT_IRQ=2. After IACK/IEND, INT_IRQ=3 one cycle after IEND's effect. SRC_ACK order is 010 then 100.
- Source 3 presented in REQ, then a source 1 edge arrives → INT_IRQ stays 3 until IACK. Source 1 is presented after IEND.
- Source 2 edge, then a second source 2 edge before IACK → OVERRUN=010, only one ACK/DONE pair. An edge in the same cycle as IACK → PENDING[2] stays 1, OVERRUN unchanged.
- IEND pulse while IDLE, and IACK pulse while in SERVICE → PROTO_ERR=1 stays set, state unchanged. RESET during SERVICE → all outputs return to 0 and no SRC_DONE is issued.
- INTC_TIMEOUT_EN, ACK_TIMEOUT=8: request with no IACK → TIMEOUT pulse after 8 REQ cycles, INT_IRQ=0 for 1 cycle, then re-presented. IACK on cycle 8 → normal ACK, no TIMEOUT.
